// File: rtl/wb_fta_bridge_x_if.sv
// FTA bus package and request/response interface used by the bridge.
// Ports: interface carries req (master -> fabric) and resp (fabric -> master).
// Latency: none (pure wiring); backpressure is signalled through resp.stall.

package fta_bus_pkg;
  // Error codes returned with a response
  localparam logic [2:0] OKAY    = 3'd0;
  localparam logic [2:0] DECERR  = 3'd1;
  localparam logic [2:0] PROTERR = 3'd2;
  localparam logic [2:0] ERR     = 3'd3;
  // Bus commands
  localparam logic [4:0] CMD_NONE  = 5'd0;
  localparam logic [4:0] CMD_LOAD  = 5'd1;
  localparam logic [4:0] CMD_STORE = 5'd2;
endpackage

interface fta_bus_interface #(
  parameter int WID = 256
) ();
  typedef struct packed {
    logic             cyc;
    logic             we;
    logic [4:0]       cmd;
    logic [12:0]      tid;
    logic [7:0]       blen;
    logic [WID/8-1:0] sel;
    logic [31:0]      adr;
    logic [WID-1:0]   data1;
  } req_t;

  typedef struct packed {
    logic             ack;
    logic             rty;
    logic             stall;
    logic [2:0]       err;
    logic [12:0]      tid;
    logic [WID-1:0]   dat;
  } resp_t;

  req_t  req;
  resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

// File: rtl/wb_fta_bridge_x.sv
// Wishbone slave to FTA master bridge with a 16-byte CSR window (src/dst/blen/go).
// Ports: Wishbone slave side (cs_i, cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
//   ack_o, err_o, dat_o), busy_o status, fta_o FTA master bundle.
// Latency: CSR access acks 2 cycles after req; bus accesses ack on FTA response,
//   after TIMEOUT cycles with ERR, or (posted writes) one cycle after issue.
// Backpressure: resp.stall holds the bridge in ISSUE; rty reissues after RTY_DLY.
// Option: define WB_FTA_BRIDGE_WRITE_ACK_EN to make writes wait for the FTA ack.

module wb_fta_bridge_x
  import fta_bus_pkg::*;
#(
  parameter int          WID      = 256,
  parameter logic [5:0]  CORENO   = 6'd1,
  parameter logic [2:0]  CHANNEL  = 3'd0,
  parameter int          RETRIES  = 100,
  parameter int          RTY_DLY  = 4,
  parameter int          TIMEOUT  = 1023,
  parameter logic [31:0] CSR_BASE = 32'hBFFFFFF0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cs_i,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [WID/8-1:0] sel_i,
  input  logic [31:0]      adr_i,
  input  logic [WID-1:0]   dat_i,
  output logic             ack_o,
  output logic [2:0]       err_o,
  output logic [WID-1:0]   dat_o,
  output logic             busy_o,
  fta_bus_interface.master fta_o
);

  localparam int RCW = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
  localparam int WCW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int DCW = (RTY_DLY < 2) ? 1 : $clog2(RTY_DLY);

  typedef enum logic [2:0] {IDLE, CSR, ISSUE, WAIT, RDLY, DONE} state_t;

  state_t           r_state;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [7:0]       r_blen;
  logic [3:0]       r_tag;
  logic [RCW-1:0]   r_rty_cnt;
  logic [WCW-1:0]   r_wait_cnt;
  logic [DCW-1:0]   r_dly_cnt;
  logic             r_burst;
  logic             r_posted;

  logic             w_req;
  logic             w_in_win;
  logic             w_burst;
  logic             w_csr;
  logic [12:0]      w_tid;
  logic [3:0]       w_tag_nxt;
  logic             w_match;
  logic [31:0]      w_csr_rd;

  assign w_req     = cs_i & cyc_i & stb_i;
  assign w_in_win  = (adr_i[31:4] == CSR_BASE[31:4]);
  assign w_burst   = w_in_win & (adr_i[3:2] == 2'b11);
  assign w_csr     = w_in_win & ~w_burst;
  assign w_tid     = {CORENO, CHANNEL, r_tag};
  // Tag 0 is never used, so the sequence wraps 15 -> 1
  assign w_tag_nxt = (r_tag == 4'd15) ? 4'd1 : r_tag + 4'd1;
  assign w_match   = (fta_o.resp.ack | fta_o.resp.rty) & (fta_o.resp.tid == w_tid);
  assign busy_o    = (r_state != IDLE);

  always_comb begin
    w_csr_rd = 32'd0;
    case (adr_i[3:2])
      2'd0:    w_csr_rd = r_src;
      2'd1:    w_csr_rd = r_dst;
      default: w_csr_rd = {24'd0, r_blen};
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_src      <= '0;
      r_dst      <= '0;
      r_blen     <= '0;
      r_tag      <= 4'd1;
      r_rty_cnt  <= '0;
      r_wait_cnt <= '0;
      r_dly_cnt  <= '0;
      r_burst    <= 1'b0;
      r_posted   <= 1'b0;
      ack_o      <= 1'b0;
      err_o      <= OKAY;
      dat_o      <= '0;
      fta_o.req  <= '0;
    end else begin
      // Request and ack are single-cycle pulses
      fta_o.req <= '0;
      ack_o     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_burst <= w_burst;
            if (w_csr) begin
              r_state <= CSR;
            end else begin
              r_rty_cnt <= '0;
              r_state   <= ISSUE;
            end
          end
        end
        CSR: begin
          if (we_i) begin
            case (adr_i[3:2])
              2'd0:    r_src  <= dat_i[31:0];
              2'd1:    r_dst  <= dat_i[31:0];
              default: r_blen <= dat_i[7:0];
            endcase
          end else begin
            dat_o <= {(WID/32){w_csr_rd}};
          end
          err_o   <= OKAY;
          ack_o   <= 1'b1;
          r_state <= DONE;
        end
        ISSUE: begin
          if (!cyc_i) begin
            r_tag   <= w_tag_nxt;
            r_state <= IDLE;
          end else if (!fta_o.resp.stall) begin
            fta_o.req.cyc   <= 1'b1;
            fta_o.req.we    <= we_i;
            fta_o.req.cmd   <= we_i ? CMD_STORE : CMD_LOAD;
            fta_o.req.tid   <= w_tid;
            fta_o.req.data1 <= dat_i;
            if (r_burst) begin
              fta_o.req.blen <= r_blen;
              fta_o.req.sel  <= '1;
              fta_o.req.adr  <= we_i ? r_dst : r_src;
            end else begin
              fta_o.req.blen <= 8'd0;
              fta_o.req.sel  <= sel_i;
              fta_o.req.adr  <= adr_i;
            end
`ifdef WB_FTA_BRIDGE_WRITE_ACK_EN
            r_posted <= 1'b0;
`else
            r_posted <= we_i;
`endif
            r_wait_cnt <= '0;
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (!cyc_i) begin
            r_tag   <= w_tag_nxt;
            r_state <= IDLE;
          end else if (r_posted) begin
            // Posted write: the eventual response carries a stale tag and is dropped
            err_o   <= OKAY;
            dat_o   <= '0;
            ack_o   <= 1'b1;
            r_tag   <= w_tag_nxt;
            r_state <= DONE;
          end else if (w_match && fta_o.resp.ack) begin
            dat_o   <= fta_o.resp.dat;
            err_o   <= fta_o.resp.err;
            ack_o   <= 1'b1;
            r_tag   <= w_tag_nxt;
            r_state <= DONE;
          end else if (w_match) begin
            // rty wins over a coinciding timeout
            if (r_rty_cnt == RCW'(RETRIES)) begin
              err_o   <= ERR;
              dat_o   <= '0;
              ack_o   <= 1'b1;
              r_tag   <= w_tag_nxt;
              r_state <= DONE;
            end else begin
              r_rty_cnt <= r_rty_cnt + 1'b1;
              r_dly_cnt <= '0;
              r_state   <= RDLY;
            end
          end else if (r_wait_cnt == WCW'(TIMEOUT)) begin
            err_o   <= ERR;
            dat_o   <= '0;
            ack_o   <= 1'b1;
            r_tag   <= w_tag_nxt;
            r_state <= DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        RDLY: begin
          r_wait_cnt <= '0;
          if (!cyc_i) begin
            r_tag   <= w_tag_nxt;
            r_state <= IDLE;
          end else if (r_dly_cnt == DCW'(RTY_DLY - 1)) begin
            r_state <= ISSUE;
          end else begin
            r_dly_cnt <= r_dly_cnt + 1'b1;
          end
        end
        DONE: begin
          // Wait for the master to drop the strobe so a held stb is one access
          if (!w_req) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_fta_bridge_x.sv
// Testbench for wb_fta_bridge_x: directed vectors plus multi-cycle sequences.
// Ports: none; drives the Wishbone side and models an FTA slave.
// Latency/backpressure: slave response delay, rty count and stall are bench knobs.

module tb_wb_fta_bridge_x;
  import fta_bus_pkg::*;

  localparam int          WID      = 64;
  localparam logic [31:0] CSR_BASE = 32'hBFFFFFF0;
  localparam int          RTY_DLY  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cs = 1'b0, cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [7:0]      sel = '0;
  logic [31:0]     adr = '0;
  logic [WID-1:0]  wdat = '0;
  logic            ack;
  logic [2:0]      err;
  logic [WID-1:0]  dat;
  logic            busy;

  fta_bus_interface #(.WID(WID)) fta ();

  wb_fta_bridge_x #(
    .WID(WID), .CORENO(6'd1), .CHANNEL(3'd0), .RETRIES(100),
    .RTY_DLY(RTY_DLY), .TIMEOUT(1023), .CSR_BASE(CSR_BASE)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .cs_i(cs), .cyc_i(cyc), .stb_i(stb),
    .we_i(we), .sel_i(sel), .adr_i(adr), .dat_i(wdat),
    .ack_o(ack), .err_o(err), .dat_o(dat), .busy_o(busy), .fta_o(fta)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // FTA slave model
  int             slv_dly = 2;
  int             rty_left = 0;
  bit             slv_stale = 1'b0;
  bit             slv_stall = 1'b0;
  logic [63:0]    slv_dat = '0;
  logic [2:0]     slv_err = OKAY;
  int             req_n = 0;
  int             req_cyc_q[$];
  logic [12:0]    req_tid_q[$];
  logic [31:0]    last_adr = '0;
  logic [7:0]     last_blen = '0;
  logic [7:0]     last_sel = '0;
  logic [12:0]    last_tid = '0;
  int             pend_cnt = 0;
  bit             pend_rty = 1'b0;
  logic [12:0]    pend_tid = '0;

  initial begin
    fta.resp = '0;
    forever begin
      @(negedge clk);
      fta.resp.ack   = 1'b0;
      fta.resp.rty   = 1'b0;
      fta.resp.stall = slv_stall;
      if (fta.req.cyc) begin
        req_n++;
        req_cyc_q.push_back(cyc_n);
        req_tid_q.push_back(fta.req.tid);
        last_adr  = fta.req.adr;
        last_blen = fta.req.blen;
        last_sel  = fta.req.sel;
        last_tid  = fta.req.tid;
        pend_tid  = fta.req.tid;
        pend_cnt  = slv_dly;
        if (rty_left > 0) begin
          pend_rty = 1'b1;
          rty_left--;
        end else begin
          pend_rty = 1'b0;
        end
      end else if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          fta.resp.tid = slv_stale ? (pend_tid ^ 13'd1) : pend_tid;
          fta.resp.ack = !pend_rty;
          fta.resp.rty = pend_rty;
          fta.resp.dat = slv_dat;
          fta.resp.err = slv_err;
        end
      end
    end
  end

  int ack_pulses = 0;
  initial forever begin
    @(negedge clk);
    if (ack) ack_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Wishbone master
  logic [63:0] rd_dat = '0;
  logic [2:0]  rd_err = '0;
  int          ack_at = 0;

  task automatic wb_do(input logic w, input logic [31:0] a, input logic [63:0] d,
                       input logic [7:0] s, input int hold, input int budget);
    bit got = 1'b0;
    @(negedge clk);
    cs = 1'b1; cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (ack) begin
        got    = 1'b1;
        rd_dat = dat;
        rd_err = err;
        ack_at = cyc_n;
      end
    end
    chk("ack_seen", {63'd0, got}, 64'd1);
    repeat (hold) @(negedge clk);
    cs = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [63:0] wdat;
    logic [7:0]  sel;
    logic [63:0] rsp_dat;
    logic [2:0]  rsp_err;
    logic [63:0] exp_dat;
    logic [2:0]  exp_err;
    logic [3:0]  exp_tag;   // 0: no FTA request expected
    logic [31:0] exp_adr;
    logic [7:0]  exp_blen;
    logic [7:0]  exp_sel;
  } vec_t;

  vec_t vt[11];

  function automatic logic [63:0] tid_of(input logic [3:0] t);
    return {51'd0, 6'd1, 3'd0, t};
  endfunction

  int r0, a0;

  initial begin
    vt[0]  = '{1'b1, CSR_BASE,        64'h2000, 8'hFF, 64'h0, OKAY, 64'h0, OKAY, 4'd0, 32'h0, 8'h0, 8'h0};
    vt[1]  = '{1'b1, CSR_BASE + 32'h4, 64'h3000, 8'hFF, 64'h0, OKAY, 64'h0, OKAY, 4'd0, 32'h0, 8'h0, 8'h0};
    vt[2]  = '{1'b1, CSR_BASE + 32'h8, 64'h0107, 8'hFF, 64'h0, OKAY, 64'h0, OKAY, 4'd0, 32'h0, 8'h0, 8'h0};
    vt[3]  = '{1'b0, CSR_BASE,        64'h0, 8'hFF, 64'h0, OKAY, 64'h00002000_00002000, OKAY, 4'd0, 32'h0, 8'h0, 8'h0};
    vt[4]  = '{1'b0, CSR_BASE + 32'h8, 64'h0, 8'hFF, 64'h0, OKAY, 64'h00000007_00000007, OKAY, 4'd0, 32'h0, 8'h0, 8'h0};
    vt[5]  = '{1'b0, CSR_BASE + 32'h4, 64'h0, 8'hFF, 64'h0, OKAY, 64'h00003000_00003000, OKAY, 4'd0, 32'h0, 8'h0, 8'h0};
    vt[6]  = '{1'b0, 32'h1004, 64'h0, 8'h0F, 64'h1122334455667788, OKAY, 64'h1122334455667788, OKAY, 4'd2, 32'h1004, 8'h0, 8'h0F};
    vt[7]  = '{1'b0, CSR_BASE + 32'hC, 64'h0, 8'h01, 64'hDEADBEEFCAFEF00D, OKAY, 64'hDEADBEEFCAFEF00D, OKAY, 4'd3, 32'h2000, 8'h7, 8'hFF};
    vt[8]  = '{1'b0, 32'h1008, 64'h0, 8'hFF, 64'h55, PROTERR, 64'h55, PROTERR, 4'd4, 32'h1008, 8'h0, 8'hFF};
    vt[9]  = '{1'b1, CSR_BASE + 32'hC, 64'h99, 8'h03, 64'h0, OKAY, 64'h0, OKAY, 4'd5, 32'h3000, 8'h7, 8'hFF};
    vt[10] = '{1'b1, 32'h1010, 64'h77, 8'hF0, 64'h0, OKAY, 64'h0, OKAY, 4'd6, 32'h1010, 8'h0, 8'hF0};

    // Reset state
    #12;
    chk("rst_ack",  {63'd0, ack}, 64'd0);
    chk("rst_err",  {61'd0, err}, {61'd0, OKAY});
    chk("rst_dat",  dat, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_req",  {63'd0, fta.req.cyc}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset while waiting for a response
    slv_dly = 8;
    @(negedge clk);
    cs = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h1000; sel = 8'hFF;
    repeat (3) @(negedge clk);
    chk("wait_busy", {63'd0, busy}, 64'd1);
    chk("wait_reqs", 64'(req_n), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ack",  {63'd0, ack}, 64'd0);
    chk("arst_err",  {61'd0, err}, {61'd0, OKAY});
    chk("arst_dat",  dat, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_req",  {63'd0, fta.req.cyc}, 64'd0);
    cs = 1'b0; cyc = 1'b0; stb = 1'b0;
    #10 rst_n = 1'b1;
    a0 = ack_pulses;
    repeat (12) @(negedge clk);
    chk("arst_late_ack", 64'(ack_pulses - a0), 64'd0);
    chk("arst_no_req",   64'(req_n), 64'd1);

    // Read with held strobe, slave acks after 5 cycles
    slv_dly = 5;
    slv_dat = {8{8'hA5}};
    slv_err = OKAY;
    r0 = req_n; a0 = ack_pulses;
    wb_do(1'b0, 32'h1000, 64'h0, 8'hFF, 3, 100);
    chk("rd_dat",   rd_dat, {8{8'hA5}});
    chk("rd_err",   {61'd0, rd_err}, {61'd0, OKAY});
    chk("rd_tid",   {51'd0, last_tid}, tid_of(4'd1));
    chk("rd_adr",   {32'd0, last_adr}, 64'h1000);
    chk("rd_nreq",  64'(req_n - r0), 64'd1);
    chk("rd_nack",  64'(ack_pulses - a0), 64'd1);

    // Vector table: CSR window and ordinary accesses
    slv_dly = 2;
    for (int i = 0; i < 11; i++) begin
      slv_dat = vt[i].rsp_dat;
      slv_err = vt[i].rsp_err;
      r0 = req_n;
      wb_do(vt[i].we, vt[i].adr, vt[i].wdat, vt[i].sel, 0, 100);
      chk($sformatf("v%0d_err", i), {61'd0, rd_err}, {61'd0, vt[i].exp_err});
      if (!vt[i].we) chk($sformatf("v%0d_dat", i), rd_dat, vt[i].exp_dat);
      if (vt[i].exp_tag != 4'd0) begin
        chk($sformatf("v%0d_nreq", i), 64'(req_n - r0), 64'd1);
        chk($sformatf("v%0d_tid", i),  {51'd0, last_tid}, tid_of(vt[i].exp_tag));
        chk($sformatf("v%0d_adr", i),  {32'd0, last_adr}, {32'd0, vt[i].exp_adr});
        chk($sformatf("v%0d_blen", i), {56'd0, last_blen}, {56'd0, vt[i].exp_blen});
        chk($sformatf("v%0d_sel", i),  {56'd0, last_sel}, {56'd0, vt[i].exp_sel});
      end else begin
        chk($sformatf("v%0d_nreq", i), 64'(req_n - r0), 64'd0);
      end
    end

    // Three rty responses, then ack
    repeat (4) @(negedge clk);
    slv_dly = 1; rty_left = 3; slv_dat = 64'h0123456789ABCDEF; slv_err = OKAY;
    req_cyc_q.delete(); req_tid_q.delete();
    r0 = req_n;
    wb_do(1'b0, 32'h1020, 64'h0, 8'hFF, 0, 300);
    chk("rty_nreq", 64'(req_n - r0), 64'd4);
    chk("rty_err",  {61'd0, rd_err}, {61'd0, OKAY});
    chk("rty_dat",  rd_dat, 64'h0123456789ABCDEF);
    for (int i = 0; i < req_tid_q.size(); i++)
      chk($sformatf("rty_tid%0d", i), {51'd0, req_tid_q[i]}, tid_of(4'd7));
    for (int i = 1; i < req_cyc_q.size(); i++)
      chk($sformatf("rty_gap%0d", i), {63'd0, (req_cyc_q[i] - req_cyc_q[i-1] - 1) >= RTY_DLY}, 64'd1);

    // Silent slave with a stale-tid ack inside the window
    repeat (4) @(negedge clk);
    slv_dly = 10; slv_stale = 1'b1; slv_dat = 64'hFFFF;
    req_cyc_q.delete(); req_tid_q.delete();
    r0 = req_n; a0 = ack_pulses;
    wb_do(1'b0, 32'h1030, 64'h0, 8'hFF, 0, 1500);
    chk("to_nreq", 64'(req_n - r0), 64'd1);
    chk("to_tid",  {51'd0, last_tid}, tid_of(4'd8));
    chk("to_err",  {61'd0, rd_err}, {61'd0, ERR});
    chk("to_dat",  rd_dat, 64'd0);
    if (req_cyc_q.size() > 0) chk("to_lat", 64'(ack_at - req_cyc_q[0]), 64'd1024);
    chk("to_nack", 64'(ack_pulses - a0), 64'd1);
    slv_stale = 1'b0;

    // Write issued while stall is held
    repeat (4) @(negedge clk);
    slv_dly = 2; slv_err = OKAY; slv_stall = 1'b1;
    req_cyc_q.delete(); req_tid_q.delete();
    r0 = req_n;
    fork
      wb_do(1'b1, 32'h1040, 64'h4242, 8'hFF, 0, 100);
      begin
        repeat (5) @(negedge clk);
        chk("stall_noreq", 64'(req_n - r0), 64'd0);
        slv_stall = 1'b0;
      end
    join
    chk("stall_nreq", 64'(req_n - r0), 64'd1);
    chk("stall_tid",  {51'd0, last_tid}, tid_of(4'd9));
    chk("stall_err",  {61'd0, rd_err}, {61'd0, OKAY});
`ifdef WB_FTA_BRIDGE_WRITE_ACK_EN
    if (req_cyc_q.size() > 0) chk("stall_wlat", 64'(ack_at - req_cyc_q[0]), 64'd3);
`else
    if (req_cyc_q.size() > 0) chk("stall_wlat", 64'(ack_at - req_cyc_q[0]), 64'd1);
`endif

    repeat (4) @(negedge clk);
    chk("end_busy", {63'd0, busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_fta_bridge_x.md
Name: wb_fta_bridge_x

Overview:
- Parametrised Wishbone-slave to FTA-master bridge, successor to the fixed 256-bit bridge.
- Adds async active-low reset, rotating transaction tags, genuine retry reissue, response timeout and FTA error propagation.
- Keeps the 16-byte CSR window for burst source/destination/length/go.
- Sits between a Wishbone-only master (CPU or DMA shim) and the FTA bus fabric.

Parameters:
- WID, 256: data width in bits; multiple of 32.
- CORENO, 6'd1: core number in the upper tid field.
- CHANNEL, 3'd0: channel field of the tid.
- RETRIES, 100: maximum reissues after rty before the bridge reports an error.
- RTY_DLY, 4: idle cycles between an rty response and the reissue.
- TIMEOUT, 1023: cycles waiting for a response before the bridge reports an error.
- CSR_BASE, 32'hBFFFFFF0: base of the CSR window; aligned to 16 bytes.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- cs_i  in  1  chip select.
- cyc_i  in  1  Wishbone cycle.
- stb_i  in  1  Wishbone strobe.
- we_i  in  1  write enable.
- sel_i  in  WID/8  byte lane selects.
- adr_i  in  32  byte address.
- dat_i  in  WID  write data.
- ack_o  out  1  acknowledge; single-cycle pulse.
- err_o  out  3  fta_bus_pkg error code, valid with ack_o.
- dat_o  out  WID  read data, valid with ack_o.
- busy_o  out  1  high whenever the state machine is not in IDLE.
- fta_o  fta_bus_interface.master  FTA request/response bundle.

Behaviour:
- Reset (rst_ni low, async): ack_o=0, err_o=OKAY, dat_o=0, busy_o=0, fta_o.req=0, src/dst=0, blen=0, tag=1, counters=0, state=IDLE.
- fta_o.req is a one-cycle pulse; it is zero in every cycle it is not issued.
- req = cs_i & cyc_i & stb_i.
- States: IDLE, CSR, ISSUE, WAIT, RDLY, DONE.
- IDLE:
  - req with adr_i in CSR_BASE+0/4/8 -> CSR.
  - Any other req, including CSR_BASE+C -> ISSUE.
- CSR:
  - Write loads src(+0) = dat_i[31:0], dst(+4) = dat_i[31:0], blen(+8) = dat_i[7:0].
  - Read returns the register replicated across WID/32 lanes; blen is zero-extended.
  - ack_o=1 this cycle, err_o=OKAY -> DONE. Latency from req: 2 cycles.
- ISSUE:
  - Drives cyc=1, we=we_i, cmd=CMD_STORE/CMD_LOAD, tid={CORENO,CHANNEL,tag}.
  - Ordinary access: blen=0, sel=sel_i, adr=adr_i, data1=dat_i.
  - CSR_BASE+C: blen=blen, sel=all ones, adr=we_i?dst:src.
  - If fta_o.resp.stall, nothing is issued and the state stays ISSUE.
  - Otherwise the request is issued -> WAIT, with the wait counter cleared.
- WAIT: only responses with ack or rty whose tid equals the current tid count; all others are ignored.
  - ack: dat_o=resp.dat, err_o=resp.err, ack_o=1, tag advances -> DONE.
  - rty: if rty_cnt==RETRIES, err_o=ERR, ack_o=1, dat_o=0 -> DONE; else rty_cnt+1 -> RDLY.
  - Wait counter reaching TIMEOUT: err_o=ERR, ack_o=1, dat_o=0, tag advances -> DONE.
- RDLY: waits RTY_DLY cycles -> ISSUE with the same tid.
- Abort: cyc_i falling in ISSUE, WAIT or RDLY -> IDLE with no ack, tag advances, so late responses are discarded.
- Tag: 4 bits, sequence 1..15, wraps 15 -> 1; never 0.
- DONE: ack_o=0; returns to IDLE once req is low. A held stb therefore never produces a second access.
- rty_cnt clears on entry to ISSUE from IDLE.
- Simultaneous rty and timeout: the rty takes priority and the wait counter clears in RDLY.

Optional Feature:
- Macro: WB_FTA_BRIDGE_WRITE_ACK_EN.
- Defined: writes are handled exactly like reads in WAIT. ack_o waits for the FTA ack; rty, timeout and error apply.
- Undefined: writes are posted. ack_o=1 in the cycle after the non-stalled issue, err_o=OKAY -> DONE. Responses to posted writes are ignored.

Test Plan:
- Reset mid-WAIT (rst_ni low for 1 cycle, asynchronous) -> all outputs 0/OKAY immediately, state IDLE; the later matching ack is ignored and produces no ack_o.
- Read 0x00001000, slave acks tid {1,0,1} after 5 cycles with dat=0xA5.. -> ack_o pulses once with dat_o=0xA5..; the next access uses tag 2.
- Write src=0x2000 to CSR_BASE+0, blen=7 to CSR_BASE+8, then read CSR_BASE+C -> one req with adr=0x2000, blen=7, sel all ones; reading CSR_BASE+8 returns 0x00000007 in every lane.
- Slave returns rty 3 times, then ack, with RTY_DLY=4 -> 4 requests issued, each separated by at least 4 idle cycles, all with the same tid; err_o=OKAY.
- Slave silent with TIMEOUT=1023 -> ack_o 1024 cycles after issue, err_o=ERR. An ack carrying a stale tid inside the window is ignored.
- Write with stall held for 3 cycles -> no req while stalled; macro undefined: ack_o one cycle after the issue; macro defined: ack_o only after the FTA ack.
